// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, start/ready/done handshake.
// One full-subtractor cell plus shift registers replaces the borrow chain.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, res, res_nx;
  logic [CW-1:0]    cnt;
  logic             bw, bw_nx, d, last;

  assign d     = a_sr[0] ^ b_sr[0] ^ bw;
  assign bw_nx = (~a_sr[0] & b_sr[0])
               | (~(a_sr[0] ^ b_sr[0]) & bw);
  assign last  = (cnt == CW'(WIDTH - 1));

  // New bit enters at the MSB so the LSB-first stream lands in order
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nx = d;
    end else begin : g_wn
      assign res_nx = {d, res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = (state == IDLE);
    done     = (state == DONE);
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      bw     <= 1'b0;
      cnt    <= '0;
      out    <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            res  <= '0;
            bw   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bw   <= bw_nx;
          res  <= res_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            out    <= res_nx;
            borrow <= bw_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
